// File: rtl/shift_seq_pkg.sv
// Shared types and widths for the shift-register load/shift sequencer.
package shift_seq_pkg;

  localparam int CNT_W      = 8;
  localparam int WORD_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO that queues parallel words ahead of the sequencer.
// The head entry is presented combinationally on rdata.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_load_sequencer.sv
// Control stage for the 4-bit left shift register: pulls words from a FIFO,
// strobes load with the word, then issues SHIFTS shift enables per word.
module shift_load_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int SHIFTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   hold,
  output logic                   load,
  output logic [WIDTH-1:0]       d,
  output logic                   shift_en,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [WORD_CNT_W-1:0]  words_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFTS - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             last_shift;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(in_data),
    .rdata(head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // No bypass: a full FIFO refuses a word even when a pop happens that cycle.
  assign in_ready   = !rst && !fifo_full;
  assign push       = in_valid && in_ready;
  assign shift_en   = (state == SHIFT) && !hold;
  assign last_shift = shift_en && (shift_cnt == LAST_CNT);
  assign pop        = !fifo_empty && (((state == IDLE) && !hold) || last_shift);
  assign busy       = (state != IDLE) || !fifo_empty;

  // The final shift edge chains straight into the next LOAD so that words
  // stream at one per SHIFTS+1 cycles with no idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_cnt  <= '0;
      load       <= 1'b0;
      d          <= '0;
      words_done <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state <= LOAD;
            load  <= 1'b1;
            d     <= head;
          end
        end
        LOAD: begin
          state     <= SHIFT;
          shift_cnt <= '0;
        end
        SHIFT: begin
          if (last_shift) begin
            words_done <= words_done + 1'b1;
            if (pop) begin
              state <= LOAD;
              load  <= 1'b1;
              d     <= head;
            end else begin
              state <= IDLE;
            end
          end else if (shift_en) begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Directed bench for shift_load_sequencer (WIDTH=4, DEPTH=4, SHIFTS=4):
// a cycle-by-cycle vector table plus hand-written multi-cycle sequences.
module tb_shift_load_sequencer;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [3:0] data;
    logic       hold;
    logic       ready;
    logic       load;
    logic [3:0] d;
    logic       shift_en;
    logic       busy;
    logic [2:0] count;
    logic [7:0] wd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       hold;
  logic       load;
  logic [3:0] d;
  logic       shift_en;
  logic       busy;
  logic [2:0] fifo_count;
  logic [7:0] words_done;

  int   compared = 0;
  int   failed   = 0;
  vec_t vecs[$];

  logic hold_seq[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic load_seq[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic shen_seq[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic busy_seq[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] full_words[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};

  shift_load_sequencer #(
    .WIDTH (4),
    .DEPTH (4),
    .SHIFTS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .hold      (hold),
    .load      (load),
    .d         (d),
    .shift_en  (shift_en),
    .busy      (busy),
    .fifo_count(fifo_count),
    .words_done(words_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic r, logic v, logic [3:0] dt, logic h,
                              logic rdy, logic ld, logic [3:0] dd, logic sh,
                              logic bz, logic [2:0] cnt, logic [7:0] wd);
    vec_t x;
    x = {r, v, dt, h, rdy, ld, dd, sh, bz, cnt, wd};
    return x;
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] dt, input logic h);
    rst      = r;
    in_valid = v;
    in_data  = dt;
    hold     = h;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t e);
    checkField($sformatf("vec%0d.in_ready", idx), 8'(in_ready), 8'(e.ready));
    checkField($sformatf("vec%0d.load", idx), 8'(load), 8'(e.load));
    checkField($sformatf("vec%0d.d", idx), 8'(d), 8'(e.d));
    checkField($sformatf("vec%0d.shift_en", idx), 8'(shift_en), 8'(e.shift_en));
    checkField($sformatf("vec%0d.busy", idx), 8'(busy), 8'(e.busy));
    checkField($sformatf("vec%0d.fifo_count", idx), 8'(fifo_count), 8'(e.count));
    checkField($sformatf("vec%0d.words_done", idx), words_done, e.wd);
  endtask

  initial begin
    int         loads;
    int         pushed;
    logic [7:0] prev_wd;
    logic       seen255;
    logic       done;

    // Single word 1101 from idle: load one cycle after the push, then four shifts.
    vecs.push_back(mk(0, 1, 4'hD, 0, 1, 0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4'h0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 1, 4'hD, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4'hD, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4'hD, 0, 0, 0, 1));
    // Back-to-back 1101, 0110, 1011: load pulses five cycles apart.
    vecs.push_back(mk(0, 1, 4'hD, 0, 1, 0, 4'hD, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'h6, 0, 1, 0, 4'hD, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 4'hB, 0, 1, 1, 4'hD, 0, 1, 1, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4'hD, 1, 1, 2, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 1, 4'h6, 0, 1, 1, 2));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4'h6, 1, 1, 1, 2));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 1, 4'hB, 0, 1, 0, 3));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4'hB, 1, 1, 0, 3));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4'hB, 0, 0, 0, 4));

    // Reset values, sampled while rst is still asserted.
    applyStimulus(1, 0, 4'h0, 0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkField("reset.in_ready", 8'(in_ready), 8'd0);
    checkField("reset.load", 8'(load), 8'd0);
    checkField("reset.d", 8'(d), 8'd0);
    checkField("reset.shift_en", 8'(shift_en), 8'd0);
    checkField("reset.busy", 8'(busy), 8'd0);
    checkField("reset.fifo_count", 8'(fifo_count), 8'd0);
    checkField("reset.words_done", words_done, 8'd0);
    nextCycle();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].hold);
      @(negedge clk);
      checkOutput(i, vecs[i]);
      nextCycle();
    end

    // Full FIFO under hold: the fifth word is refused, then exactly four issue.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, full_words[k], 1);
      @(negedge clk);
      checkField($sformatf("full.count%0d", k), 8'(fifo_count), 8'(k));
      checkField($sformatf("full.ready%0d", k), 8'(in_ready), (k < 4) ? 8'd1 : 8'd0);
      nextCycle();
    end
    applyStimulus(0, 0, 4'h0, 1);
    @(negedge clk);
    checkField("full.held_count", 8'(fifo_count), 8'd4);
    checkField("full.held_load", 8'(load), 8'd0);
    checkField("full.held_busy", 8'(busy), 8'd1);
    nextCycle();
    loads = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(0, 0, 4'h0, 0);
      @(negedge clk);
      if (load === 1'b1) begin
        if (loads < 4) checkField($sformatf("full.d%0d", loads), 8'(d), 8'(full_words[loads]));
        loads++;
      end
      nextCycle();
    end
    checkField("full.loads", 8'(loads), 8'd4);
    checkField("full.words_done", words_done, 8'd8);
    checkField("full.final_count", 8'(fifo_count), 8'd0);
    checkField("full.final_busy", 8'(busy), 8'd0);

    // Hold for three cycles after the second shift pauses shifting only.
    applyStimulus(0, 1, 4'h9, 0);
    nextCycle();
    applyStimulus(0, 0, 4'h0, 0);
    nextCycle();
    for (int t = 0; t < 9; t++) begin
      applyStimulus(0, 0, 4'h0, hold_seq[t]);
      @(negedge clk);
      checkField($sformatf("hold.load%0d", t), 8'(load), 8'(load_seq[t]));
      checkField($sformatf("hold.shift_en%0d", t), 8'(shift_en), 8'(shen_seq[t]));
      checkField($sformatf("hold.busy%0d", t), 8'(busy), 8'(busy_seq[t]));
      nextCycle();
    end
    checkField("hold.words_done", words_done, 8'd9);
    checkField("hold.d", 8'(d), 8'h9);

    // Reset during the second shift with two words queued discards everything.
    applyStimulus(0, 1, 4'hA, 0);
    nextCycle();
    applyStimulus(0, 1, 4'hC, 0);
    nextCycle();
    applyStimulus(0, 1, 4'h7, 0);
    nextCycle();
    applyStimulus(0, 0, 4'h0, 0);
    nextCycle();
    applyStimulus(1, 0, 4'h0, 0);
    @(negedge clk);
    checkField("rstmid.shift_en", 8'(shift_en), 8'd1);
    checkField("rstmid.count", 8'(fifo_count), 8'd2);
    checkField("rstmid.in_ready", 8'(in_ready), 8'd0);
    nextCycle();
    applyStimulus(0, 0, 4'h0, 0);
    @(negedge clk);
    checkField("rstmid.load", 8'(load), 8'd0);
    checkField("rstmid.d", 8'(d), 8'd0);
    checkField("rstmid.shift_en_after", 8'(shift_en), 8'd0);
    checkField("rstmid.busy", 8'(busy), 8'd0);
    checkField("rstmid.fifo_count", 8'(fifo_count), 8'd0);
    checkField("rstmid.words_done", words_done, 8'd0);
    checkField("rstmid.in_ready_after", 8'(in_ready), 8'd1);
    nextCycle();
    loads = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (load !== 1'b0 || busy !== 1'b0) loads++;
      nextCycle();
    end
    checkField("rstmid.quiet", 8'(loads), 8'd0);

    // Stream 256 words: words_done steps by one, reaches 255, then wraps to 0.
    pushed  = 0;
    prev_wd = words_done;
    seen255 = 1'b0;
    done    = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      applyStimulus(0, pushed < 256, 4'(pushed), 0);
      @(negedge clk);
      if (in_valid && in_ready) pushed++;
      if (words_done !== prev_wd) begin
        checkField("wrap.step", words_done, prev_wd + 8'd1);
        if (words_done == 8'd255) seen255 = 1'b1;
        prev_wd = words_done;
      end
      if (pushed == 256 && !busy) done = 1'b1;
      nextCycle();
    end
    checkField("wrap.completed", 8'(done), 8'd1);
    checkField("wrap.seen255", 8'(seen255), 8'd1);
    checkField("wrap.final", words_done, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/shift_load_sequencer.md
# shift_load_sequencer

Upstream control stage for the 4-bit left shift register. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. For each word it drives the register's `load`/`d` for one cycle, then `shift_en` for a fixed number of cycles. Its outputs connect directly to the shift register's `load`, `d` and `shift_en` inputs.

## Interface
Parameters:
- `WIDTH`, default 4: word width; matches the shift register's `d`.
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `SHIFTS`, default 4: `shift_en` cycles per word; range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WIDTH  upstream word.
- `in_ready`  out  1  FIFO can accept a word.
- `hold`  in  1  pause request.
- `load`  out  1  load strobe to the shift register.
- `d`  out  WIDTH  parallel data to the shift register.
- `shift_en`  out  1  shift enable to the shift register.
- `busy`  out  1  a word is in flight or queued.
- `fifo_count`  out  $clog2(DEPTH)+1  number of queued words.
- `words_done`  out  8  completed-word counter; wraps 255→0.

## Operation
- Push: on an edge where `in_valid && in_ready`, `in_data` is written to the FIFO tail.
- `in_ready = !rst && (fifo_count < DEPTH)`.
  - No bypass path: when the FIFO is full, `in_ready` stays 0 even on a cycle where a pop occurs.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE:
  - If `fifo_count != 0 && !hold`: at the edge, pop the head into `d` and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `load = 1` for exactly one cycle; `hold` is ignored.
  - Next state is always SHIFT, with the shift counter cleared to 0.
- SHIFT:
  - `shift_en = !hold` (combinational, from the registered state).
  - The counter increments only on cycles where `shift_en = 1`.
  - On the edge that completes shift number SHIFTS:
    - `words_done` increments.
    - If `fifo_count != 0 && !hold`: pop the head into `d` and go to LOAD.
    - Else: go to IDLE.
- `d` is registered. It holds its last loaded value outside LOAD.
- `load` and `shift_en` are never asserted in the same cycle.
- `busy = (state != IDLE) || (fifo_count != 0)`.
- A simultaneous push and pop on the same edge leaves `fifo_count` unchanged.
- FIFO pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - state IDLE; FIFO empty; `fifo_count = 0`.
  - `d = 0`, `load = 0`, `shift_en = 0`, `busy = 0`, `words_done = 0`.
  - `in_ready = 0` while `rst` is high.
- Reset mid-operation (during LOAD or SHIFT) discards the in-flight word and all queued words.
- Latency: word pushed at edge E0 into an empty, idle block:
  - After E1: LOAD cycle, with `load = 1` and `d = word`.
  - After E2 through E(1+SHIFTS): `shift_en = 1`.
- Sustained throughput: one word per SHIFTS+1 cycles, with no IDLE gap between words.
- `hold` has no effect on pushes.
- With `hold` asserted continuously, at most one more LOAD occurs, and only if the LOAD transition had already been taken.

## Structure
- Package `shift_seq_pkg`:
  - state enum `seq_state_t` (IDLE, LOAD, SHIFT).
  - localparams `CNT_W = 8`, `WORD_CNT_W = 8`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata (head), count, full, empty.
  - synchronous reset, same `clk`/`rst`.
- The top level contains the FSM, the shift counter, the `d` register and `words_done`.

## Test plan
- Single word: after reset, push 4'b1101 → `load = 1`, `d = 1101` exactly one cycle later; then `shift_en = 1` for 4 cycles; `words_done = 1`; `busy = 0` after.
- Back-to-back: push 1101, 0110, 1011 on consecutive cycles → three LOAD pulses spaced 5 cycles apart, `d` in order; `words_done = 3`.
- Full FIFO: hold high, push 5 words → `in_ready = 0` once `fifo_count = 4`; the 5th word is not accepted; release hold → exactly 4 words issued.
- Hold mid-shift: assert `hold` for 3 cycles after the 2nd `shift_en` → `shift_en` low for those 3 cycles; 4 total shifts still issued; LOAD→IDLE spans 4+3 cycles.
- Reset mid-shift: `rst` during the 2nd shift with 2 words queued → next cycle all outputs at reset values; `fifo_count = 0`; no further `load`.
- Counter wrap: stream 256 words (SHIFTS=1) → `words_done` reads 255 then 0.
